tff_bank_ctrl: RTL

- Sequencing controller for a bank of WIDTH T flip-flops (T_FF cells, toggle on clk rising edge when t=1, cleared by reset).
- Computes per-bit toggle enables from the bank's q feedback so the bank behaves as a mod-MODULUS up/down counter.
- Supports start/stop, load and clear commands via a valid/ready handshake, plus a one-shot mode.
- Sits between the lab's control logic and the T_FF bank; it holds no count register of its own.

---
 rtl/tff_bank_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tff_bank_ctrl.sv
// rtl/tff_bank_ctrl.sv - toggle-enable sequencer that makes a T flip-flop bank count mod MODULUS
//
// Purpose:
//   Drives the t inputs of an external bank of WIDTH T flip-flops. The bank's q
//   outputs feed back into the controller, and the controller computes the bits to
//   toggle. With these toggle bits the bank behaves as a mod-MODULUS up/down counter.
//   The controller holds no count register of its own. Commands use a valid/ready
//   handshake and are START, STOP, LOAD and CLEAR. A one-shot run stops at the
//   terminal count.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   reset      synchronous active-low reset, shared with the bank
//   tick       count enable while running
//   up_dn      1 = count up, 0 = count down
//   oneshot    captured when START is accepted
//   cmd_valid  command request
//   cmd_ready  controller can accept a command
//   cmd        0 START, 1 STOP, 2 LOAD, 3 CLEAR
//   cmd_data   LOAD value; values above MODULUS-1 are clamped
//   q          bank outputs (feedback)
//   t          bank toggle inputs
//   busy       controller is running
//   tc         a terminal-count step is applied this cycle
//   done       a one-shot run has completed
//   err        (TFF_BANK_CTRL_CHECK_EN only) sticky flag: bank differs from the expected value
//
// Build option:
//   TFF_BANK_CTRL_CHECK_EN adds an expected-value tracker and the err output.

module tff_bank_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             tc,
`ifdef TFF_BANK_CTRL_CHECK_EN
  output logic             err,
`endif
  output logic             done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_LOAD  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             os_latch;
  logic             done_r;

  logic             accept;
  logic             count_en;
  logic             at_top;
  logic             at_bottom;
  logic             terminal;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] load_target;

  // Handshake. While a LOAD/CLEAR is pending, no command is accepted, so a
  // pending op always lasts exactly one cycle.
  assign cmd_ready = reset && !pend_valid;
  assign accept    = cmd_valid && cmd_ready;

  // A pending op takes priority over counting in its cycle.
  assign count_en  = reset && (state == S_RUN) && tick && !pend_valid;

  // A value out of range (q >= MODULUS) is handled as terminal in both
  // directions. This steers a corrupted bank back into range within one step.
  assign at_top    = (q >= LAST);
  assign at_bottom = (q == '0) || (q > LAST);

  assign load_target = (cmd_data > LAST) ? LAST : cmd_data;

  always_comb begin
    terminal  = 1'b0;
    count_nxt = q;
    if (up_dn) begin
      terminal  = at_top;
      count_nxt = at_top ? '0 : (q + ONE);
    end else begin
      terminal  = at_bottom;
      count_nxt = at_bottom ? LAST : (q - ONE);
    end
  end

  // Toggle bits are the XOR between the present bank value and the value the
  // bank must hold after the next edge.
  always_comb begin
    t = '0;
    if (!reset) begin
      t = '0;
    end else if (pend_valid) begin
      t = q ^ pend_target;
    end else if (count_en) begin
      t = q ^ count_nxt;
    end
  end

  assign tc   = count_en && terminal;
  assign busy = reset && (state == S_RUN);
  assign done = reset && done_r;

  // Next-state logic. The count-driven one-shot exit is evaluated first, so an
  // accepted command in the same cycle overrides it.
  always_comb begin
    state_nxt = state;
    if (tc && os_latch) begin
      state_nxt = S_DONE;
    end
    if (accept) begin
      if (cmd == CMD_START) begin
        state_nxt = S_RUN;
      end else if ((cmd == CMD_STOP) && (state == S_RUN)) begin
        state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
      os_latch    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (tc && os_latch) begin
        done_r <= 1'b1;
      end
      if (accept) begin
        case (cmd)
          CMD_START: begin
            done_r   <= 1'b0;
            os_latch <= oneshot;
          end
          CMD_LOAD: begin
            pend_valid  <= 1'b1;
            pend_target <= load_target;
          end
          CMD_CLEAR: begin
            pend_valid  <= 1'b1;
            pend_target <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef TFF_BANK_CTRL_CHECK_EN
  // The bank value expected after each edge is the present value with the
  // requested toggles applied. Any other value means the bank was disturbed.
  logic [WIDTH-1:0] exp_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_q <= '0;
      err   <= 1'b0;
    end else begin
      exp_q <= q ^ t;
      if (accept && (cmd == CMD_CLEAR)) begin
        err <= 1'b0;
      end else if (q != exp_q) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule
